// File: rtl/exp3_unidade_controle_if.sv
// Command/status bundle between the experiment-3 control unit and its datapath.
// The control unit (master) issues counter/register commands and reads back
// the comparison result and the end-of-sequence flag from the datapath (slave).
interface exp3_unidade_controle_if;
    logic zeraC;               // synchronous address-counter clear
    logic contaC;              // address-counter enable
    logic zeraR;               // switch-register clear
    logic registraR;           // switch-register load
    logic chavesIgualMemoria;  // registered switches equal ROM data
    logic fimC;                // address counter at its last entry

    modport master (
        output zeraC,
        output contaC,
        output zeraR,
        output registraR,
        input  chavesIgualMemoria,
        input  fimC
    );

    modport slave (
        input  zeraC,
        input  contaC,
        input  zeraR,
        input  registraR,
        output chavesIgualMemoria,
        output fimC
    );
endinterface

// File: rtl/exp3_unidade_controle.sv
// Moore control unit for the experiment-3 memory-check round.
// Starts a round, captures each new switch press, checks the datapath
// comparison and walks the 16-entry address counter. A round ends in a hit,
// an error or an inactivity timeout and then waits for a restart request.
module exp3_unidade_controle #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      iniciar,
    input  logic [3:0]                chaves,
    exp3_unidade_controle_if.master   dp,
    output logic                      pronto,
    output logic                      acertou,
    output logic                      errou,
    output logic                      timeout,
    output logic [3:0]                db_estado
);

    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'b0000,
        PREPARA     = 4'b0001,
        ESPERA      = 4'b0010,
        REGISTRA    = 4'b0011,
        COMPARA     = 4'b0100,
        PROXIMO     = 4'b0101,
        FIM_ACERTO  = 4'b1010,
        FIM_ERRO    = 4'b1110,
        FIM_TIMEOUT = 4'b1101
    } estado_t;

    // Output vector layout:
    // [7] zeraC [6] contaC [5] zeraR [4] registraR
    // [3] pronto [2] acertou [1] errou [0] timeout
    function automatic logic [7:0] decodifica_saidas(input estado_t e);
        logic [7:0] s;
        s = 8'b0000_0000;
        case (e)
            PREPARA:     s = 8'b1010_0000;
            REGISTRA:    s = 8'b0001_0000;
            PROXIMO:     s = 8'b0100_0000;
            FIM_ACERTO:  s = 8'b0000_1100;
            FIM_ERRO:    s = 8'b0000_1010;
            FIM_TIMEOUT: s = 8'b0000_1001;
            default:     s = 8'b0000_0000;
        endcase
        return s;
    endfunction

    estado_t       r_estado;
    estado_t       w_prox;
    logic [TW-1:0] r_timer;
    logic          r_prev;
    logic          w_jogada_raw;
    logic          w_jogada;
    logic [7:0]    r_saidas;

    assign w_jogada_raw = |chaves;
    // Only a rising edge of "any switch on" counts as a move, so a switch
    // already held when waiting begins is not taken as a new move.
    assign w_jogada     = w_jogada_raw & ~r_prev;

    // Track the previous switch activity every cycle, in every state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_jogada_raw;
        end
    end

    // Inactivity timer: counts only while waiting for a move, zero elsewhere,
    // so entry from PREPARA or PROXIMO always starts it at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (r_estado == ESPERA) begin
            r_timer <= r_timer + TW'(1);
        end else begin
            r_timer <= '0;
        end
    end

    // State register; outputs are registered from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= INICIAL;
            r_saidas <= 8'b0000_0000;
        end else begin
            r_estado <= w_prox;
            r_saidas <= decodifica_saidas(w_prox);
        end
    end

    // Next-state logic of the round sequencer.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL: begin
                if (iniciar) begin
                    w_prox = PREPARA;
                end else begin
                    w_prox = INICIAL;
                end
            end
            PREPARA: begin
                w_prox = ESPERA;
            end
            ESPERA: begin
                // A move on the expiry cycle still counts as a move.
                if (w_jogada) begin
                    w_prox = REGISTRA;
                end else if (r_timer == TIMER_MAX) begin
                    w_prox = FIM_TIMEOUT;
                end else begin
                    w_prox = ESPERA;
                end
            end
            REGISTRA: begin
                w_prox = COMPARA;
            end
            COMPARA: begin
                if (!dp.chavesIgualMemoria) begin
                    w_prox = FIM_ERRO;
                end else if (dp.fimC) begin
                    w_prox = FIM_ACERTO;
                end else begin
                    w_prox = PROXIMO;
                end
            end
            PROXIMO: begin
                w_prox = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) begin
                    w_prox = PREPARA;
                end else begin
                    w_prox = r_estado;
                end
            end
            default: begin
                w_prox = INICIAL;
            end
        endcase
    end

    assign dp.zeraC     = r_saidas[7];
    assign dp.contaC    = r_saidas[6];
    assign dp.zeraR     = r_saidas[5];
    assign dp.registraR = r_saidas[4];
    assign pronto       = r_saidas[3];
    assign acertou      = r_saidas[2];
    assign errou        = r_saidas[1];
    assign timeout      = r_saidas[0];
    assign db_estado    = r_estado;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Bench for exp3_unidade_controle: drives a small behavioural datapath
// (counter, switch register, synchronous ROM) and checks whole rounds
// against an outcome predicted from the move list and the ROM sequence.
module tb_exp3_unidade_controle;

    localparam int T = 8;

    localparam logic [3:0] S_INICIAL  = 4'b0000;
    localparam logic [3:0] S_PREPARA  = 4'b0001;
    localparam logic [3:0] S_ESPERA   = 4'b0010;
    localparam logic [3:0] S_REGISTRA = 4'b0011;
    localparam logic [3:0] S_ACERTO   = 4'b1010;
    localparam logic [3:0] S_ERRO     = 4'b1110;
    localparam logic [3:0] S_TIMEOUT  = 4'b1101;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] chaves  = 4'b0000;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;

    int cnt_conta = 0;
    int cnt_reg   = 0;
    int cnt_zera  = 0;

    logic [3:0] vals  [16];
    int         gaps  [16];
    int         holds [16];

    exp3_unidade_controle_if dp_if();

    exp3_unidade_controle #(.TIMEOUT_CICLOS(T)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .iniciar   (iniciar),
        .chaves    (chaves),
        .dp        (dp_if),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] rom_val(input int i);
        case (i)
            0: return 4'd1;   1: return 4'd2;   2: return 4'd4;   3: return 4'd8;
            4: return 4'd4;   5: return 4'd2;   6: return 4'd1;   7: return 4'd1;
            8: return 4'd2;   9: return 4'd2;  10: return 4'd4;  11: return 4'd4;
           12: return 4'd8;  13: return 4'd8;  14: return 4'd1;  15: return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    // Behavioural datapath
    logic [3:0] dp_addr, dp_reg, dp_q;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dp_addr <= 4'd0;
            dp_reg  <= 4'd0;
            dp_q    <= 4'd0;
        end else begin
            if (dp_if.zeraC)       dp_addr <= 4'd0;
            else if (dp_if.contaC) dp_addr <= dp_addr + 4'd1;
            if (dp_if.zeraR)          dp_reg <= 4'd0;
            else if (dp_if.registraR) dp_reg <= chaves;
            dp_q <= rom_val(int'(dp_addr));
        end
    end
    assign dp_if.chavesIgualMemoria = (dp_reg == dp_q);
    assign dp_if.fimC               = (dp_addr == 4'd15);

    // Command pulse counters, sampled mid-cycle
    always @(negedge clock) begin
        if (reset_n && dp_if.contaC)    cnt_conta <= cnt_conta + 1;
        if (reset_n && dp_if.registraR) cnt_reg   <= cnt_reg + 1;
        if (reset_n && dp_if.zeraC)     cnt_zera  <= cnt_zera + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_db"}, 32'(db_estado), 32'(S_INICIAL));
        chk({tag, "_outs"}, 32'({dp_if.zeraC, dp_if.contaC, dp_if.zeraR, dp_if.registraR,
                                  pronto, acertou, errou, timeout}), 32'd0);
    endtask

    task automatic start_round;
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        chk("prep_db", 32'(db_estado), 32'(S_PREPARA));
        chk("prep_zera", 32'({dp_if.zeraC, dp_if.zeraR}), 32'd3);
        chk("prep_flags", 32'({pronto, errou, acertou, timeout}), 32'd0);
        tick;
        chk("espera_entry", 32'(db_estado), 32'(S_ESPERA));
    endtask

    task automatic wait_end(input int bound);
        int n;
        n = 0;
        while (!pronto && n < bound) begin
            tick;
            n++;
        end
        chk("end_reached", 32'(pronto), 32'd1);
    endtask

    // Plays vals/gaps/holds as one round and checks against the predicted outcome
    task automatic run_round(input string tag);
        int  c0, r0, z0, n;
        int  exp_conta, exp_reg;
        logic [3:0] exp_state;
        bit  fim;

        exp_state = S_ACERTO;
        exp_conta = 15;
        exp_reg   = 16;
        for (int i = 0; i < 16; i++) begin
            if (gaps[i] >= T) begin
                exp_state = S_TIMEOUT; exp_conta = i; exp_reg = i;
                break;
            end
            if (vals[i] != rom_val(i)) begin
                exp_state = S_ERRO; exp_conta = i; exp_reg = i + 1;
                break;
            end
        end

        c0 = cnt_conta; r0 = cnt_reg; z0 = cnt_zera;
        start_round;
        fim = 1'b0;
        for (int i = 0; i < 16 && !fim; i++) begin
            if (i > 0) begin
                n = 0;
                while (!(db_estado == S_ESPERA || pronto) && n < 12) begin
                    tick;
                    n++;
                end
            end
            if (pronto) begin
                fim = 1'b1;
            end else begin
                for (int k = 0; k < gaps[i] && !pronto; k++) tick;
                if (pronto) begin
                    fim = 1'b1;
                end else begin
                    chaves = vals[i];
                    repeat (holds[i]) tick;
                    chaves = 4'b0000;
                end
            end
        end
        wait_end(40);

        chk({tag, "_state"},   32'(db_estado), 32'(exp_state));
        chk({tag, "_acertou"}, 32'(acertou), 32'(exp_state == S_ACERTO));
        chk({tag, "_errou"},   32'(errou),   32'(exp_state == S_ERRO));
        chk({tag, "_timeout"}, 32'(timeout), 32'(exp_state == S_TIMEOUT));
        chk({tag, "_contaC"},  32'(cnt_conta - c0), 32'(exp_conta));
        chk({tag, "_regR"},    32'(cnt_reg - r0),   32'(exp_reg));
        chk({tag, "_zeraC"},   32'(cnt_zera - z0),  32'd1);
    endtask

    task automatic fill_correct;
        for (int i = 0; i < 16; i++) begin
            vals[i]  = rom_val(i);
            gaps[i]  = $urandom_range(0, T - 1);
            holds[i] = $urandom_range(2, 3);
        end
    endtask

    initial begin
        int n, r0, mode, idx;
        logic [3:0] v;

        // Reset and idle
        reset_n = 1'b0;
        repeat (3) tick;
        check_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (5) tick;
        check_idle_outputs("idle");

        // Full correct round
        fill_correct;
        run_round("full");

        // Error on move 3: 1,2 then 0001 instead of 0100
        fill_correct;
        vals[2] = 4'b0001;
        run_round("err3");

        // Timeout: exactly T cycles in ESPERA
        start_round;
        n = 0;
        while (db_estado == S_ESPERA && n < 20) begin
            tick;
            n++;
        end
        chk("to_cycles", 32'(n), 32'(T));
        chk("to_state", 32'(db_estado), 32'(S_TIMEOUT));
        chk("to_flags", 32'({pronto, timeout, errou, acertou}), 32'b1100);

        // Move on the last ESPERA cycle wins over expiry
        start_round;
        repeat (T - 1) tick;
        chk("prio_still_wait", 32'(db_estado), 32'(S_ESPERA));
        chaves = 4'b0001;
        tick;
        chk("prio_registra", 32'(db_estado), 32'(S_REGISTRA));
        tick;
        chaves = 4'b0000;
        wait_end(40);

        // Held switch does not count; release and re-press does
        chaves = 4'b0010;
        start_round;
        r0 = cnt_reg;
        repeat (3) tick;
        chk("held_wait", 32'(db_estado), 32'(S_ESPERA));
        chk("held_no_reg", 32'(cnt_reg - r0), 32'd0);
        chaves = 4'b0000;
        tick;
        chaves = 4'b0010;
        tick;
        chk("repress_reg", 32'(db_estado), 32'(S_REGISTRA));
        tick;
        chk("repress_pulse", 32'(cnt_reg - r0), 32'd1);
        chaves = 4'b0000;
        tick;
        chk("repress_err", 32'({db_estado, errou}), 32'({S_ERRO, 1'b1}));

        // Restart from FIM_ERRO (errou must drop on PREPARA entry, checked in start_round)
        fill_correct;
        run_round("restart");

        // Asynchronous reset in the middle of ESPERA
        start_round;
        repeat (2) tick;
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) tick;
        check_idle_outputs("after_reset");

        // Randomized rounds
        for (int r = 0; r < 12; r++) begin
            fill_correct;
            mode = $urandom_range(0, 2);
            idx  = $urandom_range(0, 15);
            if (mode == 1) begin
                v = 4'(($urandom_range(1, 15)));
                while (v == rom_val(idx)) v = 4'(($urandom_range(1, 15)));
                vals[idx] = v;
            end else if (mode == 2) begin
                gaps[idx] = $urandom_range(T, T + 3);
            end
            run_round($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
